// File: rtl/mem_stage_lat_pkg.sv
// Purpose: shared types for the MEM stage: memory op codes, FSM states, WB register layout, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  // Memory operation codes carried down the pipe from decode.
  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LW   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LHU  = 4'd3,
    MOP_LB   = 4'd4,
    MOP_LBU  = 4'd5,
    MOP_SW   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SB   = 4'd8
  } memop_e;

  // Access FSM: IDLE accepts a new op, WAIT counts down the remaining latency.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int CNT_W   = 3;
  localparam int MAX_LAT = 8;

  // Everything the MEM/WB pipeline register holds.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] bad_vaddr;
  } wb_t;

  function automatic logic is_load(input memop_e op);
    return (op == MOP_LW) || (op == MOP_LH) || (op == MOP_LHU) ||
           (op == MOP_LB) || (op == MOP_LBU);
  endfunction

  function automatic logic is_store(input memop_e op);
    return (op == MOP_SW) || (op == MOP_SH) || (op == MOP_SB);
  endfunction

  // Byte-lane enables for a store; lanes are little-endian within the word.
  function automatic logic [3:0] store_be(input memop_e op, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      MOP_SB:  be = 4'b0001 << addr_lo;
      MOP_SH:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      MOP_SW:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store operand across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] store_lanes(input memop_e op, input logic [31:0] data);
    logic [31:0] w;
    case (op)
      MOP_SB:  w = {4{data[7:0]}};
      MOP_SH:  w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Select the addressed lane(s) of a read word and sign/zero extend.
  function automatic logic [31:0] ext_load(input logic [31:0] word, input logic [1:0] addr_lo,
                                           input memop_e op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (op)
      MOP_LB:  r = {{24{b[7]}}, b};
      MOP_LBU: r = {24'h0, b};
      MOP_LH:  r = {{16{h[15]}}, h};
      MOP_LHU: r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lat_if.sv
// Purpose: MEM-stage bundle: MEM-side inputs, forwarding taps, control, stall request and MEM/WB outputs.
// Latency: n/a (wiring only).
// Backpressure: mem_busy (slave -> master) asks upstream to hold the MEM inputs.
// Ports: master = pipeline/hazard side, slave = mem_stage_lat.
interface mem_stage_lat_if;
  logic        stall;
  logic        clr;
  logic        valid_MEM;
  logic [3:0]  memop_MEM;
  logic [31:0] PC_MEM;
  logic [31:0] aluOut_MEM;
  logic [31:0] memWriteData_MEM;
  logic [4:0]  addrRt_MEM;
  logic [4:0]  regWriteAddr_MEM;
  logic [31:0] regWriteData_MEM;
  logic [4:0]  regaddr_WB;
  logic [31:0] regdata_WB;
  logic        mem_busy;
  logic        valid_WB;
  logic [31:0] PC_WB;
  logic [31:0] memReadData_WB;
  logic [4:0]  regWriteAddr_WB;
  logic [31:0] regWriteData_WB;
  logic        excAdEL_WB;
  logic        excAdES_WB;
  logic [31:0] badVAddr_WB;

  modport master (
    output stall, clr, valid_MEM, memop_MEM, PC_MEM, aluOut_MEM, memWriteData_MEM,
           addrRt_MEM, regWriteAddr_MEM, regWriteData_MEM, regaddr_WB, regdata_WB,
    input  mem_busy, valid_WB, PC_WB, memReadData_WB, regWriteAddr_WB, regWriteData_WB,
           excAdEL_WB, excAdES_WB, badVAddr_WB
  );

  modport slave (
    input  stall, clr, valid_MEM, memop_MEM, PC_MEM, aluOut_MEM, memWriteData_MEM,
           addrRt_MEM, regWriteAddr_MEM, regWriteData_MEM, regaddr_WB, regdata_WB,
    output mem_busy, valid_WB, PC_WB, memReadData_WB, regWriteAddr_WB, regWriteData_WB,
           excAdEL_WB, excAdES_WB, badVAddr_WB
  );
endinterface

// File: rtl/mem_stage_lat_array.sv
// Purpose: data memory, 2^ADDR_W x 32 words, byte-enable write, asynchronous read, cleared on reset.
// Latency: write commits at posedge; read is combinational.
// Backpressure: none; the caller gates we.
// Ports: clk/reset, we/be/wdata write side, addr shared by read and write, rdata read word.
module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lat.sv
// Purpose: MEM pipeline stage with sub-word load/store, address exceptions, WB->MEM store forwarding.
// Latency: MEM_LAT unstalled cycles per legal memory op; errors and non-memory ops take 1 cycle.
// Backpressure: mem_busy is high for the first MEM_LAT-1 cycles; upstream holds inputs meanwhile.
// Ports: clk, reset (sync, active-high), bus (slave modport of mem_stage_lat_if).
module mem_stage_lat
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1,   // 1..8
  parameter bit FWD_EN  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mem_stage_lat_if.slave bus
);

  // One past the last legal byte address; 33 bits so the limit itself fits.
  localparam logic [32:0] BYTE_LIMIT = 33'(4) << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  // ---------------- decode ----------------
  memop_e      op;
  logic [31:0] addr;
  logic        ld, st, mem_op;
  logic        misalign, out_of_range, addr_err, legal;

  assign op   = memop_e'(bus.memop_MEM);
  assign addr = bus.aluOut_MEM;
  assign ld   = is_load(op);
  assign st   = is_store(op);
  // Codes outside the defined set are treated like MOP_NONE rather than as an access.
  assign mem_op = bus.valid_MEM && (ld || st);

  always_comb begin
    misalign = 1'b0;
    case (op)
      MOP_LW, MOP_SW:          misalign = (addr[1:0] != 2'b00);
      MOP_LH, MOP_LHU, MOP_SH: misalign = addr[0];
      default:                 misalign = 1'b0;
    endcase
  end

  assign out_of_range = ({1'b0, addr} >= BYTE_LIMIT);
  assign addr_err     = mem_op && (misalign || out_of_range);
  assign legal        = mem_op && !addr_err;

  // ---------------- store-data forwarding ----------------
  logic        fwd_hit;
  logic [31:0] st_data_fwd, st_latch, st_data;

  assign fwd_hit     = FWD_EN && (bus.regaddr_WB == bus.addrRt_MEM) && (bus.regaddr_WB != 5'd0);
  assign st_data_fwd = fwd_hit ? bus.regdata_WB : bus.memWriteData_MEM;
  // With latency the WB-stage value is gone by completion, so the IDLE-cycle sample is used.
  assign st_data     = (MEM_LAT == 1) ? st_data_fwd : st_latch;

  // ---------------- access FSM ----------------
  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             busy, complete, latch_load;

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    busy       = 1'b0;
    complete   = 1'b0;
    latch_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (legal) begin
          if (MEM_LAT == 1) begin
            complete = 1'b1;
          end else begin
            busy       = 1'b1;
            cnt_n      = CNT_LOAD;
            latch_load = 1'b1;
            state_n    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        busy  = (cnt_q > CNT_W'(1));
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          complete = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ---------------- memory ----------------
  logic              mem_we;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       mem_rdata, load_val;

  assign word_addr = addr[ADDR_W+1:2];
  // Writes only on an unfrozen, unflushed completion of a store.
  assign mem_we    = complete && st && !bus.clr && !bus.stall;

  mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .addr  (word_addr),
    .be    (store_be(op, addr[1:0])),
    .wdata (store_lanes(op, st_data)),
    .rdata (mem_rdata)
  );

  assign load_val = ext_load(mem_rdata, addr[1:0], op);

  // ---------------- MEM/WB register ----------------
  wb_t wb_n, wb_q;

  always_comb begin
    wb_n = '0;
    if (!mem_op) begin
      wb_n.valid   = bus.valid_MEM;
      wb_n.pc      = bus.PC_MEM;
      wb_n.rd_addr = bus.regWriteAddr_MEM;
      wb_n.rd_data = bus.regWriteData_MEM;
    end else if (addr_err) begin
      // Faulting op still retires so the exception reaches WB; its register write is killed.
      wb_n.valid     = 1'b1;
      wb_n.pc        = bus.PC_MEM;
      wb_n.rd_data   = bus.regWriteData_MEM;
      wb_n.exc_adel  = ld;
      wb_n.exc_ades  = st;
      wb_n.bad_vaddr = addr;
    end else if (complete) begin
      wb_n.valid     = 1'b1;
      wb_n.pc        = bus.PC_MEM;
      wb_n.mem_rdata = ld ? load_val : 32'h0;
      wb_n.rd_addr   = bus.regWriteAddr_MEM;
      wb_n.rd_data   = ld ? load_val : bus.regWriteData_MEM;
    end
    // Legal op still counting down: wb_n stays an all-zero bubble.
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      st_latch <= '0;
      wb_q     <= '0;
    end else if (bus.clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else if (!bus.stall) begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      wb_q    <= wb_n;
      if (latch_load) st_latch <= st_data_fwd;
    end
  end

  assign bus.mem_busy        = busy;
  assign bus.valid_WB        = wb_q.valid;
  assign bus.PC_WB           = wb_q.pc;
  assign bus.memReadData_WB  = wb_q.mem_rdata;
  assign bus.regWriteAddr_WB = wb_q.rd_addr;
  assign bus.regWriteData_WB = wb_q.rd_data;
  assign bus.excAdEL_WB      = wb_q.exc_adel;
  assign bus.excAdES_WB      = wb_q.exc_ades;
  assign bus.badVAddr_WB     = wb_q.bad_vaddr;

endmodule

// File: tb/tb_mem_stage_lat.sv
// Purpose: directed bench for mem_stage_lat at MEM_LAT 1, 3 and 4 with a scoreboard of WB results.
// Latency: n/a.
// Backpressure: waits on mem_busy, bounded by a cycle budget.
module tb_mem_stage_lat;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid, stall, clr;
  logic [3:0]  op;
  logic [31:0] pc, addr, wdata, rwd, wb_rd;
  logic [4:0]  rt, rwa, wb_ra;
  int          sel;

  logic        o_busy [3];
  logic        o_valid[3];
  logic        o_adel [3];
  logic        o_ades [3];
  logic [31:0] o_pc   [3];
  logic [31:0] o_mrd  [3];
  logic [31:0] o_rwd  [3];
  logic [31:0] o_badv [3];
  logic [4:0]  o_rwa  [3];

  mem_stage_lat_if ifs[3] ();

  // Index 0: MEM_LAT=1, 1: MEM_LAT=3, 2: MEM_LAT=4. Only the selected DUT sees valid/stall/clr.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign ifs[k].stall            = stall && (sel == k);
    assign ifs[k].clr              = clr && (sel == k);
    assign ifs[k].valid_MEM        = valid && (sel == k);
    assign ifs[k].memop_MEM        = op;
    assign ifs[k].PC_MEM           = pc;
    assign ifs[k].aluOut_MEM       = addr;
    assign ifs[k].memWriteData_MEM = wdata;
    assign ifs[k].addrRt_MEM       = rt;
    assign ifs[k].regWriteAddr_MEM = rwa;
    assign ifs[k].regWriteData_MEM = rwd;
    assign ifs[k].regaddr_WB       = wb_ra;
    assign ifs[k].regdata_WB       = wb_rd;

    mem_stage_lat #(
      .ADDR_W  (10),
      .MEM_LAT ((k == 0) ? 1 : ((k == 1) ? 3 : 4)),
      .FWD_EN  (1'b1)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifs[k])
    );

    assign o_busy[k]  = ifs[k].mem_busy;
    assign o_valid[k] = ifs[k].valid_WB;
    assign o_adel[k]  = ifs[k].excAdEL_WB;
    assign o_ades[k]  = ifs[k].excAdES_WB;
    assign o_pc[k]    = ifs[k].PC_WB;
    assign o_mrd[k]   = ifs[k].memReadData_WB;
    assign o_rwd[k]   = ifs[k].regWriteData_WB;
    assign o_badv[k]  = ifs[k].badVAddr_WB;
    assign o_rwa[k]   = ifs[k].regWriteAddr_WB;
  end

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rwd;
    logic [31:0] mrd;
    logic [31:0] badv;
    logic [4:0]  rwa;
    logic        adel;
    logic        ades;
    logic        chk_mrd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_n   = 32'h0000_0400;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op to DUT k, push its expected WB result, ride out the busy window, pop and compare.
  task automatic do_op(input int k, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd_in, input logic [4:0] ra_in,
                       input int exp_busy, input logic [31:0] exp_load);
    logic is_ld, is_st, mis, oor, bad;
    exp_t e, got;
    int   n;
    is_ld = (o == MOP_LW) || (o == MOP_LH) || (o == MOP_LHU) || (o == MOP_LB) || (o == MOP_LBU);
    is_st = (o == MOP_SW) || (o == MOP_SH) || (o == MOP_SB);
    mis   = ((o == MOP_LW || o == MOP_SW) && (a[1:0] != 2'b00)) ||
            ((o == MOP_LH || o == MOP_LHU || o == MOP_SH) && a[0]);
    oor   = (a >= 32'h0000_1000);
    bad   = (is_ld || is_st) && (mis || oor);
    e.valid   = 1'b1;
    e.pc      = pc_n;
    e.rwa     = bad ? 5'd0 : ra_in;
    e.rwd     = (is_ld && !bad) ? exp_load : rd_in;
    e.mrd     = exp_load;
    e.chk_mrd = is_ld && !bad;
    e.adel    = bad && is_ld;
    e.ades    = bad && is_st;
    e.badv    = bad ? a : 32'h0;
    sb.push_back(e);

    sel = k; valid = 1'b1; op = o; addr = a; wdata = wd; rwd = rd_in; rwa = ra_in; pc = pc_n;
    #1;
    n = 0;
    while (o_busy[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
      chk("bubble_valid", 32'(o_valid[k]), 32'h0);
    end
    chk("busy_cycles", 32'(n), 32'(exp_busy));
    @(posedge clk); #1;
    got = sb.pop_front();
    chk("wb_valid", 32'(o_valid[k]), 32'(got.valid));
    chk("wb_pc", o_pc[k], got.pc);
    chk("wb_rwa", 32'(o_rwa[k]), 32'(got.rwa));
    chk("wb_rwd", o_rwd[k], got.rwd);
    chk("wb_adel", 32'(o_adel[k]), 32'(got.adel));
    chk("wb_ades", 32'(o_ades[k]), 32'(got.ades));
    chk("wb_badv", o_badv[k], got.badv);
    if (got.chk_mrd) chk("wb_mrd", o_mrd[k], got.mrd);
    valid = 1'b0; op = MOP_NONE;
    pc_n  = pc_n + 32'd4;
  endtask

  initial begin
    int n;
    reset = 1'b1; valid = 1'b0; stall = 1'b0; clr = 1'b0; op = MOP_NONE;
    pc = '0; addr = '0; wdata = '0; rwd = '0; rt = '0; rwa = '0; wb_ra = '0; wb_rd = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(o_valid[k]), 32'h0);
      chk("rst_rwd", o_rwd[k], 32'h0);
      chk("rst_badv", o_badv[k], 32'h0);
      chk("rst_busy", 32'(o_busy[k]), 32'h0);
    end

    // MEM_LAT=1: sub-word loads over a known word
    do_op(0, MOP_SW,  32'h10, 32'h8badf00d, 32'h0, 5'd0, 0, 32'h0);
    do_op(0, MOP_LB,  32'h13, 32'h0, 32'h0, 5'd2, 0, 32'hffffff8b);
    do_op(0, MOP_LBU, 32'h13, 32'h0, 32'h0, 5'd2, 0, 32'h0000008b);
    do_op(0, MOP_LH,  32'h12, 32'h0, 32'h0, 5'd3, 0, 32'hffff8bad);
    do_op(0, MOP_LHU, 32'h10, 32'h0, 32'h0, 5'd3, 0, 32'h0000f00d);
    do_op(0, MOP_LB,  32'h10, 32'h0, 32'h0, 5'd4, 0, 32'h0000000d);
    do_op(0, MOP_LW,  32'h10, 32'h0, 32'h0, 5'd4, 0, 32'h8badf00d);

    // Forwarding with combinational store data
    wb_ra = 5'd5; rt = 5'd5; wb_rd = 32'hcafe0001;
    do_op(0, MOP_SW, 32'h40, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    do_op(0, MOP_LW, 32'h40, 32'h0, 32'h0, 5'd6, 0, 32'hcafe0001);
    wb_ra = 5'd0; rt = 5'd0;
    do_op(0, MOP_SW, 32'h40, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    do_op(0, MOP_LW, 32'h40, 32'h0, 32'h0, 5'd6, 0, 32'h0);

    // Address errors: misaligned and out of range leave memory alone
    do_op(0, MOP_SW, 32'h0, 32'h01020304, 32'h0, 5'd0, 0, 32'h0);
    do_op(0, MOP_LW, 32'h06, 32'h0, 32'h55, 5'd9, 0, 32'h0);
    do_op(0, MOP_SW, 32'h1000, 32'hffffffff, 32'h66, 5'd9, 0, 32'h0);
    do_op(0, MOP_SH, 32'h01, 32'hffffffff, 32'h0, 5'd0, 0, 32'h0);
    do_op(0, MOP_LH, 32'h03, 32'h0, 32'h0, 5'd7, 0, 32'h0);
    do_op(0, MOP_LW, 32'h0, 32'h0, 32'h0, 5'd7, 0, 32'h01020304);

    // MEM_LAT=3
    do_op(1, MOP_SW,   32'h20, 32'haabbccdd, 32'h0, 5'd0, 2, 32'h0);
    do_op(1, MOP_SH,   32'h22, 32'h00001234, 32'h0, 5'd0, 2, 32'h0);
    do_op(1, MOP_LW,   32'h20, 32'h0, 32'h0, 5'd8, 2, 32'h1234ccdd);
    do_op(1, MOP_SB,   32'h21, 32'h00000099, 32'h0, 5'd0, 2, 32'h0);
    do_op(1, MOP_LW,   32'h20, 32'h0, 32'h0, 5'd8, 2, 32'h123499dd);
    do_op(1, MOP_NONE, 32'h20, 32'h0, 32'h77, 5'd3, 0, 32'h0);
    do_op(1, MOP_LW,   32'h06, 32'h0, 32'h0, 5'd8, 0, 32'h0);
    wb_ra = 5'd7; rt = 5'd7; wb_rd = 32'h0badc0de;
    do_op(1, MOP_SW, 32'h60, 32'h0, 32'h0, 5'd0, 2, 32'h0);
    wb_ra = 5'd0; rt = 5'd0;
    do_op(1, MOP_LW, 32'h60, 32'h0, 32'h0, 5'd8, 2, 32'h0badc0de);

    // MEM_LAT=4: two stalled cycles inside WAIT stretch the busy window from 3 to 5
    sel = 2; valid = 1'b1; op = MOP_SW; addr = 32'h80; wdata = 32'h11223344; rwa = '0; rwd = '0;
    pc = pc_n;
    #1;
    n = 0;
    while (o_busy[2] && n < 20) begin
      stall = (n == 2) || (n == 3);
      @(posedge clk); #1;
      n++;
    end
    stall = 1'b0;
    chk("stall_busy_window", 32'(n), 32'd5);
    @(posedge clk); #1;
    chk("stall_done_valid", 32'(o_valid[2]), 32'h1);
    valid = 1'b0; op = MOP_NONE; pc_n = pc_n + 32'd4;
    do_op(2, MOP_LW, 32'h80, 32'h0, 32'h0, 5'd1, 3, 32'h11223344);

    // Flush at cnt=2 of a store: nothing written, FSM idle again
    valid = 1'b1; op = MOP_SW; addr = 32'h84; wdata = 32'hdeadbeef; pc = pc_n;
    #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; valid = 1'b0; op = MOP_NONE;
    #1;
    chk("clr_valid", 32'(o_valid[2]), 32'h0);
    chk("clr_busy", 32'(o_busy[2]), 32'h0);
    pc_n = pc_n + 32'd4;
    do_op(2, MOP_LW, 32'h84, 32'h0, 32'h0, 5'd1, 3, 32'h0);

    // Reset in the middle of a MEM_LAT=3 access
    sel = 1; valid = 1'b1; op = MOP_SW; addr = 32'h24; wdata = 32'h5555aaaa; pc = pc_n;
    #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0; op = MOP_NONE;
    #1;
    chk("rst2_valid", 32'(o_valid[1]), 32'h0);
    chk("rst2_pc", o_pc[1], 32'h0);
    chk("rst2_rwd", o_rwd[1], 32'h0);
    chk("rst2_rwa", 32'(o_rwa[1]), 32'h0);
    chk("rst2_mrd", o_mrd[1], 32'h0);
    chk("rst2_exc", 32'({o_adel[1], o_ades[1]}), 32'h0);
    chk("rst2_badv", o_badv[1], 32'h0);
    chk("rst2_busy", 32'(o_busy[1]), 32'h0);
    pc_n = pc_n + 32'd4;
    do_op(1, MOP_LW, 32'h20, 32'h0, 32'h0, 5'd2, 2, 32'h0);
    do_op(1, MOP_LW, 32'h24, 32'h0, 32'h0, 5'd2, 2, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
